// File: rtl/smg_pkg.sv
// smg_pkg: shared definitions for the seven-segment display path.
// Holds the active-low segment codes (bits [6:0] = g..a), the digit count,
// the code reported for an unrecognised pattern and the segment-to-digit decode.
package smg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam logic [3:0]  DIGIT_UNKNOWN = 4'hF;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } seg_dec_t;

    function automatic seg_dec_t seg_to_digit(input logic [6:0] seg);
        seg_dec_t r;
        r.valid = 1'b1;
        r.digit = DIGIT_UNKNOWN;
        case (seg)
            SEG_0:   r.digit = 4'd0;
            SEG_1:   r.digit = 4'd1;
            SEG_2:   r.digit = 4'd2;
            SEG_3:   r.digit = 4'd3;
            SEG_4:   r.digit = 4'd4;
            SEG_5:   r.digit = 4'd5;
            SEG_6:   r.digit = 4'd6;
            SEG_7:   r.digit = 4'd7;
            SEG_8:   r.digit = 4'd8;
            SEG_9:   r.digit = 4'd9;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/smg_seg_decode.sv
// smg_seg_decode: combinational active-low segment pattern to digit decode.
// Ports:
//   seg   - active-low segments g..a
//   valid - 1 when seg is one of the ten digit patterns
//   digit - decoded value 0..9, or DIGIT_UNKNOWN when not valid
module smg_seg_decode
    import smg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] digit
);

    seg_dec_t dec;

    always_comb begin
        dec   = seg_to_digit(seg);
        valid = dec.valid;
        digit = dec.digit;
    end

endmodule

// File: rtl/smg_capture.sv
// smg_capture: receive side of the six-digit multiplexed seven-segment link.
// Samples the scan and segment buses, waits for a stable dwell, decodes each
// digit and publishes a 24-bit number once all six digits have been seen.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   Scan_Sig     - active-low one-hot digit select (bit0 -> Number_Out[3:0])
//   SMG_Data     - active-low segments, [6:0] = g..a, bit 7 (dp) ignored
//   Number_Out   - last complete frame, 4 bits per digit
//   frame_valid  - one-cycle pulse when Number_Out updates
//   frame_err    - set if any digit of the last frame had an unknown code
//   link_lost    - no capture within the last TIMEOUT cycles
module smg_capture
    import smg_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_DIGITS-1:0]     Scan_Sig,
    input  logic [7:0]                SMG_Data,
    output logic [4*NUM_DIGITS-1:0]   Number_Out,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic                      link_lost
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic                    unused_dp;
    logic [NUM_DIGITS-1:0]   s_scan_q, p_scan_q;
    logic [6:0]              s_seg_q, p_seg_q;
    logic [3:0]              cnt_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic                    acc_q;
    logic [4*NUM_DIGITS-1:0] shadow_q, number_q;
    logic                    frame_valid_q, frame_err_q, link_lost_q;
    logic [TW-1:0]           tcnt_q;

    logic [NUM_DIGITS-1:0]   scan_n, seen_new;
    logic                    scan_ok, same, capture, frame_done;
    logic                    dec_valid;
    logic [3:0]              dec_digit;
    logic [4*NUM_DIGITS-1:0] shadow_merge;

    assign unused_dp = SMG_Data[7];

    smg_seg_decode u_dec (
        .seg   (s_seg_q),
        .valid (dec_valid),
        .digit (dec_digit)
    );

    always_comb begin
        scan_n  = ~s_scan_q;
        // exactly one selected digit: non-zero and a power of two
        scan_ok = (scan_n != '0) && ((scan_n & (scan_n - 1'b1)) == '0);
        same    = scan_ok && (s_scan_q == p_scan_q) && (s_seg_q == p_seg_q);
        // fires once per dwell; the counter saturates past SETTLE-1
        capture = same && (cnt_q == 4'(SETTLE - 1));

        seen_new   = seen_q | scan_n;
        frame_done = capture && (seen_new == '1);

        shadow_merge = shadow_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_n[i]) begin
                shadow_merge[4*i +: 4] = dec_digit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_scan_q      <= '0;
            p_scan_q      <= '0;
            s_seg_q       <= '0;
            p_seg_q       <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            acc_q         <= 1'b0;
            shadow_q      <= '0;
            number_q      <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            tcnt_q        <= '0;
            link_lost_q   <= 1'b1;
        end else begin
            s_scan_q <= Scan_Sig;
            s_seg_q  <= SMG_Data[6:0];
            p_scan_q <= s_scan_q;
            p_seg_q  <= s_seg_q;

            if (!same) begin
                cnt_q <= '0;
            end else if (cnt_q != 4'(SETTLE)) begin
                cnt_q <= cnt_q + 4'd1;
            end

            frame_valid_q <= frame_done;

            if (capture) begin
                shadow_q <= shadow_merge;
                if (frame_done) begin
                    number_q    <= shadow_merge;
                    frame_err_q <= acc_q | ~dec_valid;
                    seen_q      <= '0;
                    acc_q       <= 1'b0;
                end else begin
                    seen_q <= seen_new;
                    acc_q  <= acc_q | ~dec_valid;
                end
            end

            if (capture) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TW'(TIMEOUT)) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            // a capture clears the flag on the very next cycle
            link_lost_q <= !capture && (tcnt_q == TW'(TIMEOUT));
        end
    end

    assign Number_Out  = number_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign link_lost   = link_lost_q;

endmodule

// File: tb/tb_smg_capture.sv
// tb_smg_capture: directed self-checking bench for smg_capture (SETTLE=4,
// TIMEOUT=100). Emulates the multiplexed driver, including the one-cycle
// stale segment value after each scan change.
module tb_smg_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  Scan_Sig = 6'h3F;
    logic [7:0]  SMG_Data = 8'hFF;
    logic [23:0] Number_Out;
    logic        frame_valid;
    logic        frame_err;
    logic        link_lost;

    int          checks = 0;
    int          errors = 0;
    int          fv_cnt = 0;
    int          fv_base;
    logic [23:0] last_num = '0;
    logic        last_err = 1'b0;
    logic        ll_at_fv = 1'b1;
    logic [6:0]  cur_seg = 7'h7F;

    smg_capture #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Scan_Sig    (Scan_Sig),
        .SMG_Data    (SMG_Data),
        .Number_Out  (Number_Out),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .link_lost   (link_lost)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample on the falling edge and log any frame.
    task automatic tick();
        @(negedge clk);
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            last_num = Number_Out;
            last_err = frame_err;
            ll_at_fv = link_lost;
        end
    endtask

    // Driver dwell: one stale cycle with the previous pattern, then the new one.
    task automatic show_seg(input int idx, input logic [6:0] seg, input int dwell);
        Scan_Sig = ~(6'b000001 << idx);
        SMG_Data = {1'b1, cur_seg};
        tick();
        SMG_Data = {1'b1, seg};
        cur_seg  = seg;
        repeat (dwell - 1) tick();
    endtask

    task automatic show_digit(input int idx, input logic [3:0] val);
        show_seg(idx, enc(val), 20);
    endtask

    task automatic show_frame(input logic [23:0] n);
        for (int d = 0; d < 6; d++) show_digit(d, n[4*d +: 4]);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (5) tick();
        check("reset_num", 32'(Number_Out), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_ll", 32'(link_lost), 32'h1);
        rst = 1'b0;

        // Nominal frame
        show_frame(24'h123456);
        check("nom_fv_cnt", 32'(fv_cnt), 32'd1);
        check("nom_num", 32'(last_num), 32'h123456);
        check("nom_ferr", 32'(last_err), 32'h0);
        check("nom_ll_at_fv", 32'(ll_at_fv), 32'h0);
        check("nom_ll_now", 32'(link_lost), 32'h0);

        // Unknown code on digit 2
        show_digit(0, 4'd6);
        show_digit(1, 4'd5);
        show_seg(2, 7'h7F, 20);
        show_digit(3, 4'd3);
        show_digit(4, 4'd2);
        show_digit(5, 4'd1);
        check("bad_fv_cnt", 32'(fv_cnt), 32'd2);
        check("bad_num", 32'(last_num), 32'h123F56);
        check("bad_ferr", 32'(last_err), 32'h1);
        repeat (5) tick();
        check("bad_ferr_hold", 32'(frame_err), 32'h1);
        check("bad_num_hold", 32'(Number_Out), 32'h123F56);

        // Clean frame after the bad one
        show_frame(24'h654321);
        check("clean_fv_cnt", 32'(fv_cnt), 32'd3);
        check("clean_num", 32'(last_num), 32'h654321);
        check("clean_ferr", 32'(last_err), 32'h0);

        // Glitch rejection on digit 0 after digits 1..5 of 24'h876540
        show_digit(1, 4'd4);
        show_digit(2, 4'd5);
        show_digit(3, 4'd6);
        show_digit(4, 4'd7);
        show_digit(5, 4'd8);
        Scan_Sig = 6'b111110;
        for (int i = 0; i < 6; i++) begin
            SMG_Data = {1'b1, enc(4'd2)};
            tick();
            tick();
            SMG_Data = {1'b1, enc(4'd3)};
            tick();
            tick();
        end
        check("glitch_no_frame", 32'(fv_cnt), 32'd3);
        SMG_Data = {1'b1, enc(4'd0)};
        cur_seg  = enc(4'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fv_cnt == 4) break;
        end
        check("glitch_stable_fv", 32'(fv_cnt), 32'd4);
        check("glitch_num", 32'(last_num), 32'h876540);

        // Invalid scans and timeout, counted from the frame_valid cycle
        Scan_Sig = 6'b111111;
        for (int k = 1; k <= 130; k++) begin
            tick();
            if (k == 50) Scan_Sig = 6'b111100;
            if (k == 100) check("ll_before_timeout", 32'(link_lost), 32'h0);
            if (k == 101) check("ll_at_timeout", 32'(link_lost), 32'h1);
        end
        check("invalid_scan_no_frame", 32'(fv_cnt), 32'd4);

        // Recovery: link_lost holds until the first capture, then clears
        Scan_Sig = 6'b111110;
        SMG_Data = {1'b1, cur_seg};
        tick();
        SMG_Data = {1'b1, enc(4'd6)};
        cur_seg  = enc(4'd6);
        tick();
        check("ll_before_capture", 32'(link_lost), 32'h1);
        repeat (18) tick();
        check("ll_after_capture", 32'(link_lost), 32'h0);
        show_digit(1, 4'd5);
        show_digit(2, 4'd4);
        show_digit(3, 4'd3);
        show_digit(4, 4'd2);
        show_digit(5, 4'd1);
        check("relink_fv_cnt", 32'(fv_cnt), 32'd5);
        check("relink_num", 32'(last_num), 32'h123456);

        // Reset mid-frame after three digits, asserted between edges
        show_digit(0, 4'd9);
        show_digit(1, 4'd9);
        show_digit(2, 4'd9);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_num", 32'(Number_Out), 32'h0);
        check("async_ll", 32'(link_lost), 32'h1);
        check("async_fv", 32'(frame_valid), 32'h0);
        tick();
        rst = 1'b0;
        fv_base = fv_cnt;
        show_digit(3, 4'd5);
        show_digit(4, 4'd3);
        show_digit(5, 4'd1);
        check("midrst_no_frame", 32'(fv_cnt), 32'(fv_base));
        show_digit(0, 4'd2);
        show_digit(1, 4'd9);
        show_digit(2, 4'd7);
        check("midrst_fv", 32'(fv_cnt), 32'(fv_base + 1));
        check("midrst_num", 32'(last_num), 32'h135792);
        check("midrst_ferr", 32'(last_err), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
